irf_wb_sched: RTL and testbench
===============================

Name: irf_wb_sched

Overview:
- Write-back scheduler and scoreboard for the 8x8-bit internal register file (one write port, two read ports).
- Arbitrates the single write port between two write-back requesters: ALU result (requester 0) and memory load (requester 1). Each requester uses a valid/ready handshake.
- Keeps an 8-bit pending-write scoreboard, set at issue and cleared at commit, and flags read-after-write hazards for both read addresses.
- Sits between the decode/issue logic, the execute/memory stages and the register file's we/aRW/d inputs.

Parameters:
- ZERO_PROTECT, 1: when 1, register 0 is read-only. Writes to address 0 complete the handshake but never assert we. Issues to address 0 never set pending.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- alu_valid  in  1  ALU write-back request.
- alu_addr  in  3  ALU destination register.
- alu_data  in  8  ALU result.
- alu_ready  out  1  ALU request accepted this cycle (combinational).
- mem_valid  in  1  load write-back request.
- mem_addr  in  3  load destination register.
- mem_data  in  8  load data.
- mem_ready  out  1  load request accepted this cycle (combinational).
- iss_valid  in  1  an instruction with destination iss_addr is issuing.
- iss_addr  in  3  destination of the issuing instruction.
- iss_ready  out  1  issue allowed: ~pending[iss_addr] (write-after-write guard).
- rd_addr_a  in  3  register-file read address A (mirrors aRA).
- rd_addr_b  in  3  register-file read address B (mirrors aRB).
- hz_a  out  1  pending[rd_addr_a] (combinational).
- hz_b  out  1  pending[rd_addr_b] (combinational).
- rf_we  out  1  to register-file we (registered).
- rf_aw  out  3  to register-file aRW (registered).
- rf_d  out  8  to register-file d (registered).
- pending  out  8  scoreboard state.
- err  out  1  sticky: a commit targeted a non-pending register.

Behaviour:
- Reset, synchronous on clk when rst=1: rf_we=0, rf_aw=0, rf_d=0, pending=0, err=0, rr_ptr=0 (ALU has priority). Reset overrides any handshake in the same cycle.
- Arbitration, combinational:
  - Only one valid: that requester is granted.
  - Both valid: the requester indicated by rr_ptr is granted.
  - Neither valid: no grant.
  - ready is asserted only for the granted requester. At most one ready per cycle.
  - The ungranted requester must hold valid/addr/data stable until accepted.
- Round-robin: on every accept by requester i, rr_ptr <= ~i at the same edge. rr_ptr is unchanged when there is no accept.
- Accept at edge T:
  - rf_aw <= addr and rf_d <= data.
  - rf_we <= 1, except rf_we <= 0 when ZERO_PROTECT=1 and addr=0.
  - With no accept: rf_we <= 0, and rf_aw/rf_d hold their values.
- The register file captures the write at edge T+1. Latency from accept to register update is 2 edges.
- Scoreboard update each edge, for k = 0..7:
  - Set pending[k] when iss_valid & iss_ready & iss_addr=k, except no set for k=0 when ZERO_PROTECT=1.
  - Clear pending[k] when rf_we=1 and rf_aw=k. The clear takes effect at the same edge the register file writes.
- Simultaneous set and clear of the same k cannot occur, because iss_ready=0 while pending[k]=1. Set and clear of different registers in the same cycle both apply.
- hz_a/hz_b drop in the cycle after the register-file write edge. Reads then return the new value; there is no bypass path.
- Error flag:
  - err <= 1 when an accept targets address k with pending[k]=0.
  - Zero-protected address 0 is exempt.
  - err clears only on rst.
- Back-to-back accepts on consecutive cycles are supported: one commit per cycle, full throughput.

Test Plan:
- Reset: hold rst 2 cycles with alu_valid=1 -> rf_we=0, pending=0x00, err=0, no ready during reset. First accept after reset goes to the ALU.
- Basic path: issue addr 3 -> pending=0x08. ALU writes addr 3 data 0x5A -> rf_we=1, rf_aw=3, rf_d=0x5A one edge after accept; pending=0x00 at the next edge. rd_addr_a=3 gives hz_a=1 until then, 0 after.
- Contention: issue 1 and 2. alu (1,0x11) and mem (2,0x22) both valid every cycle -> ALU granted first, mem next cycle. Writes in order 0x11 then 0x22 on consecutive cycles. pending 0x06 -> 0x04 -> 0x00.
- Round-robin fairness: keep both valid for 6 grants with fresh pending addresses -> grants alternate 0,1,0,1,0,1. mem_valid alone while rr_ptr=0 is still granted immediately.
- WAW guard and error: issue 5, then iss_valid addr 5 again -> iss_ready=0, pending stays 0x20. ALU write to addr 6 (not pending) -> err=1 and remains set until rst.
- Zero protect: issue addr 0 -> pending unchanged. mem write addr 0 data 0xFF -> mem_ready=1, rf_we stays 0, err stays 0.

Source files
------------

// File: rtl/irf_wb_sched_if.sv
// irf_wb_sched_if: handshake, issue, hazard and register-file signals of the write-back scheduler
interface irf_wb_sched_if;
  logic       alu_valid;
  logic [2:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       mem_valid;
  logic [2:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic       iss_valid;
  logic [2:0] iss_addr;
  logic       iss_ready;
  logic [2:0] rd_addr_a;
  logic [2:0] rd_addr_b;
  logic       hz_a;
  logic       hz_b;
  logic       rf_we;
  logic [2:0] rf_aw;
  logic [7:0] rf_d;
  logic [7:0] pending;
  logic       err;
  modport slave (
    input  alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           iss_valid, iss_addr, rd_addr_a, rd_addr_b,
    output alu_ready, mem_ready, iss_ready, hz_a, hz_b, rf_we, rf_aw, rf_d, pending, err
  );
  modport master (
    output alu_valid, alu_addr, alu_data, mem_valid, mem_addr, mem_data,
           iss_valid, iss_addr, rd_addr_a, rd_addr_b,
    input  alu_ready, mem_ready, iss_ready, hz_a, hz_b, rf_we, rf_aw, rf_d, pending, err
  );
endinterface

// File: rtl/irf_wb_sched.sv
// irf_wb_sched: round-robin write-back arbiter and pending-write scoreboard for an 8x8 register file
module irf_wb_sched #(
  parameter bit ZERO_PROTECT = 1'b1
) (
  input logic            clk,
  input logic            rst,
  irf_wb_sched_if.slave  bus
);
  logic       rr_ptr_q, rr_ptr_d, rf_we_q, rf_we_d, err_q, err_d;
  logic [2:0] rf_aw_q, rf_aw_d, acc_addr;
  logic [7:0] rf_d_q, rf_d_d, pending_q, pending_d, acc_data, set_mask, clr_mask;
  logic       gnt_alu, gnt_mem, acc, zp_acc, iss_ok;
  // grant the single write port; rr_ptr only matters when both requesters are valid
  always_comb begin
    gnt_alu  = ~rst & bus.alu_valid & (~bus.mem_valid | ~rr_ptr_q);
    gnt_mem  = ~rst & bus.mem_valid & (~bus.alu_valid | rr_ptr_q);
    acc      = gnt_alu | gnt_mem;
    acc_addr = gnt_mem ? bus.mem_addr : bus.alu_addr;
    acc_data = gnt_mem ? bus.mem_data : bus.alu_data;
    zp_acc   = ZERO_PROTECT && acc_addr == 3'd0;
    iss_ok   = bus.iss_valid & ~pending_q[bus.iss_addr] & ~(ZERO_PROTECT && bus.iss_addr == 3'd0);
    set_mask = iss_ok ? 8'd1 << bus.iss_addr : 8'd0;
    clr_mask = rf_we_q ? 8'd1 << rf_aw_q : 8'd0;
    rr_ptr_d  = gnt_alu ? 1'b1 : gnt_mem ? 1'b0 : rr_ptr_q;
    rf_we_d   = acc & ~zp_acc;
    rf_aw_d   = acc ? acc_addr : rf_aw_q;
    rf_d_d    = acc ? acc_data : rf_d_q;
    pending_d = (pending_q & ~clr_mask) | set_mask;
    err_d     = err_q | (acc & ~zp_acc & ~pending_q[acc_addr]);
  end
  // commit register, scoreboard and sticky error state
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q  <= 1'b0;
      rf_we_q   <= 1'b0;
      rf_aw_q   <= 3'd0;
      rf_d_q    <= 8'd0;
      pending_q <= 8'd0;
      err_q     <= 1'b0;
    end else begin
      rr_ptr_q  <= rr_ptr_d;
      rf_we_q   <= rf_we_d;
      rf_aw_q   <= rf_aw_d;
      rf_d_q    <= rf_d_d;
      pending_q <= pending_d;
      err_q     <= err_d;
    end
  end
  assign bus.alu_ready = gnt_alu;
  assign bus.mem_ready = gnt_mem;
  assign bus.iss_ready = ~pending_q[bus.iss_addr];
  assign bus.hz_a      = pending_q[bus.rd_addr_a];
  assign bus.hz_b      = pending_q[bus.rd_addr_b];
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_aw     = rf_aw_q;
  assign bus.rf_d      = rf_d_q;
  assign bus.pending   = pending_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_irf_wb_sched.sv
// tb_irf_wb_sched: directed stimulus with a commit scoreboard checked by a negedge monitor
module tb_irf_wb_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int nvec = 0;
  int nfail = 0;
  logic [10:0] exp_q[$];
  irf_wb_sched_if b();
  irf_wb_sched #(.ZERO_PROTECT(1'b1)) dut (.clk(clk), .rst(rst), .bus(b));
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #1;
  endtask
  task automatic idle();
    b.alu_valid = 0; b.mem_valid = 0; b.iss_valid = 0;
  endtask
  task automatic issue(input logic [2:0] a);
    b.iss_valid = 1; b.iss_addr = a;
    step();
    b.iss_valid = 0;
  endtask
  logic [2:0] ra[3] = '{3'd1, 3'd3, 3'd5};
  logic [7:0] rd[3] = '{8'hA1, 8'hA3, 8'hA5};
  logic [2:0] ma[3] = '{3'd2, 3'd4, 3'd6};
  logic [7:0] md[3] = '{8'hB2, 8'hB4, 8'hB6};
  initial begin
    fork
      forever begin
        @(negedge clk);
        if (b.rf_we) begin
          if (exp_q.size() == 0) chk("unexpected_commit", {b.rf_aw, b.rf_d}, 0);
          else chk("commit_aw_d", {b.rf_aw, b.rf_d}, exp_q.pop_front());
        end
      end
    join_none
    idle();
    b.alu_addr = 3'd7; b.alu_data = 8'h77; b.mem_addr = 0; b.mem_data = 0;
    b.iss_addr = 0; b.rd_addr_a = 0; b.rd_addr_b = 0;
    b.alu_valid = 1;
    step(); settle();
    chk("rst_alu_ready", b.alu_ready, 0);
    step(); settle();
    chk("rst_alu_ready2", b.alu_ready, 0);
    chk("rst_rf_we", b.rf_we, 0);
    chk("rst_pending", b.pending, 8'h00);
    chk("rst_err", b.err, 0);
    rst = 0; idle();
    step();
    issue(3'd1);
    issue(3'd2);
    chk("cont_pending0", b.pending, 8'h06);
    b.alu_valid = 1; b.alu_addr = 3'd1; b.alu_data = 8'h11;
    b.mem_valid = 1; b.mem_addr = 3'd2; b.mem_data = 8'h22;
    settle();
    chk("cont_alu_first", b.alu_ready, 1);
    chk("cont_mem_wait", b.mem_ready, 0);
    exp_q.push_back({3'd1, 8'h11});
    step();
    b.alu_valid = 0;
    settle();
    chk("cont_mem_next", b.mem_ready, 1);
    chk("cont_pending1", b.pending, 8'h06);
    exp_q.push_back({3'd2, 8'h22});
    step();
    b.mem_valid = 0;
    chk("cont_pending2", b.pending, 8'h04);
    step();
    chk("cont_pending3", b.pending, 8'h00);
    issue(3'd3);
    chk("basic_pending", b.pending, 8'h08);
    b.rd_addr_a = 3'd3; b.rd_addr_b = 3'd4;
    settle();
    chk("basic_hz_a_set", b.hz_a, 1);
    chk("basic_hz_b_clear", b.hz_b, 0);
    b.alu_valid = 1; b.alu_addr = 3'd3; b.alu_data = 8'h5A;
    settle();
    chk("basic_alu_ready", b.alu_ready, 1);
    exp_q.push_back({3'd3, 8'h5A});
    step();
    b.alu_valid = 0;
    chk("basic_rf_we", b.rf_we, 1);
    chk("basic_rf_aw", b.rf_aw, 3);
    chk("basic_rf_d", b.rf_d, 8'h5A);
    chk("basic_hz_a_hold", b.hz_a, 1);
    step();
    chk("basic_pending_clr", b.pending, 8'h00);
    chk("basic_hz_a_drop", b.hz_a, 0);
    chk("basic_rf_we_off", b.rf_we, 0);
    issue(3'd7);
    b.mem_valid = 1; b.mem_addr = 3'd7; b.mem_data = 8'h3C;
    settle();
    chk("rr_mem_alone_rr1", b.mem_ready, 1);
    exp_q.push_back({3'd7, 8'h3C});
    step();
    b.mem_valid = 0;
    for (int i = 1; i <= 6; i++) issue(3'(i));
    chk("rr_pending", b.pending, 8'h7E);
    begin
      int ia = 0;
      int im = 0;
      for (int i = 0; i < 6; i++) begin
        b.alu_valid = ia < 3; b.mem_valid = im < 3;
        if (ia < 3) begin b.alu_addr = ra[ia]; b.alu_data = rd[ia]; end
        if (im < 3) begin b.mem_addr = ma[im]; b.mem_data = md[im]; end
        settle();
        chk("rr_alu_ready", b.alu_ready, (i % 2 == 0) ? 1 : 0);
        chk("rr_mem_ready", b.mem_ready, (i % 2 == 1) ? 1 : 0);
        if (i % 2 == 0) begin exp_q.push_back({ra[ia], rd[ia]}); ia++; end
        else begin exp_q.push_back({ma[im], md[im]}); im++; end
        step();
      end
    end
    idle();
    step(); step();
    chk("rr_pending_done", b.pending, 8'h00);
    chk("rr_err", b.err, 0);
    issue(3'd4);
    b.mem_valid = 1; b.mem_addr = 3'd4; b.mem_data = 8'hC4;
    settle();
    chk("rr0_mem_alone", b.mem_ready, 1);
    chk("rr0_alu_idle", b.alu_ready, 0);
    exp_q.push_back({3'd4, 8'hC4});
    step();
    b.mem_valid = 0;
    step();
    b.iss_valid = 1; b.iss_addr = 3'd0;
    settle();
    chk("zp_iss_ready", b.iss_ready, 1);
    step();
    b.iss_valid = 0;
    chk("zp_pending", b.pending, 8'h00);
    b.mem_valid = 1; b.mem_addr = 3'd0; b.mem_data = 8'hFF;
    settle();
    chk("zp_mem_ready", b.mem_ready, 1);
    step();
    b.mem_valid = 0;
    chk("zp_rf_we", b.rf_we, 0);
    chk("zp_rf_d", b.rf_d, 8'hFF);
    step();
    chk("zp_err", b.err, 0);
    issue(3'd5);
    b.iss_valid = 1; b.iss_addr = 3'd5;
    settle();
    chk("waw_iss_ready", b.iss_ready, 0);
    step();
    b.iss_valid = 0;
    chk("waw_pending", b.pending, 8'h20);
    b.alu_valid = 1; b.alu_addr = 3'd6; b.alu_data = 8'h66;
    exp_q.push_back({3'd6, 8'h66});
    step();
    b.alu_valid = 0;
    chk("err_set", b.err, 1);
    step(); step();
    chk("err_sticky", b.err, 1);
    chk("err_pending", b.pending, 8'h20);
    rst = 1;
    step();
    rst = 0;
    settle();
    chk("rst2_err", b.err, 0);
    chk("rst2_pending", b.pending, 8'h00);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule
